// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with jump LUT interface and internal return stack
// Each RUN cycle performs one action: stall > halt > ret > call > abs_jump > taken branch > increment.
module pc_sequencer #(
    parameter int D  = 12,
    parameter int SD = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   prog_sel,
    input  logic         stall,
    input  logic         halt,
    input  logic         abs_jump,
    input  logic         call,
    input  logic         ret,
    input  logic [7:0]   jump_idx,
    input  logic         rel_branch,
    input  logic         taken,
    input  logic [7:0]   offset,
    input  logic [D-1:0] lut_target,
    output logic [7:0]   lut_addr,
    output logic [D-1:0] prog_ctr,
    output logic         busy,
    output logic         done,
    output logic         stack_err
);

    localparam int SPW = $clog2(SD + 1);
    localparam int AW  = (SD > 1) ? $clog2(SD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           push_en;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   off_ext;
    logic [SPW-1:0] sp_m1;
    logic [D-1:0]   stk_q [SD];

    assign pc_inc  = pc_q + D'(1);
    assign off_ext = D'($signed(offset));
    assign sp_m1   = sp_q - SPW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: occupancy count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_q[sp_q[AW-1:0]] <= pc_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = lut_target;
                    sp_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_RUN;
                end else if (halt) begin
                    state_d = S_DONE;
                end else if (ret) begin
                    if (sp_q == '0) begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        pc_d = stk_q[sp_m1[AW-1:0]];
                        sp_d = sp_m1;
                    end
                end else if (call) begin
                    pc_d = lut_target;
                    if (sp_q == SPW'(SD)) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                    end
                end else if (abs_jump) begin
                    pc_d = lut_target;
                end else if (rel_branch && taken) begin
                    pc_d = pc_q + off_ext;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        lut_addr = 8'h00;
        case (state_q)
            S_IDLE:  lut_addr = {4'b0000, prog_sel};
            S_RUN:   lut_addr = jump_idx;
            default: lut_addr = 8'h00;
        endcase
    end

    assign prog_ctr  = pc_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign stack_err = err_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter D, default 12, meaning the program-counter width in bits.
REQ-002 The block SHALL have parameter SD, default 4, meaning the return-stack depth in entries.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a program.
REQ-006 The block SHALL have port prog_sel, input, 4, jump-LUT index of the program entry point.
REQ-007 The block SHALL have port stall, input, 1, freeze all state this cycle.
REQ-008 The block SHALL have port halt, input, 1, current instruction ends the program.
REQ-009 The block SHALL have port abs_jump, input, 1, absolute jump through the LUT.
REQ-010 The block SHALL have port call, input, 1, absolute jump through the LUT with return-address push.
REQ-011 The block SHALL have port ret, input, 1, return to the popped address.
REQ-012 The block SHALL have port jump_idx, input, 8, LUT index for abs_jump and call.
REQ-013 The block SHALL have port rel_branch, input, 1, conditional relative branch instruction.
REQ-014 The block SHALL have port taken, input, 1, branch condition true.
REQ-015 The block SHALL have port offset, input, 8, two's-complement branch displacement.
REQ-016 The block SHALL have port lut_target, input, D, combinational target returned by the jump LUT.
REQ-017 The block SHALL have port lut_addr, output, 8, index presented to the jump LUT.
REQ-018 The block SHALL have port prog_ctr, output, D, current instruction address.
REQ-019 The block SHALL have port busy, output, 1, program running.
REQ-020 The block SHALL have port done, output, 1, one-cycle program-complete pulse.
REQ-021 The block SHALL have port stack_err, output, 1, sticky return-stack overflow/underflow flag.

Function
REQ-022 States SHALL be IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-023 lut_addr SHALL be combinational: {4'b0,prog_sel} in IDLE, jump_idx in RUN, 0 in DONE.
REQ-024 IDLE with start=1: prog_ctr<=lut_target, stack emptied, stack_err<=0, next state RUN; start=0 holds everything.
REQ-025 In RUN, start SHALL be ignored.
REQ-026 In RUN, one action per cycle by priority: stall > halt > ret > call > abs_jump > (rel_branch&taken) > increment.
REQ-027 stall=1: prog_ctr, state, stack and stack_err unchanged.
REQ-028 halt=1: prog_ctr unchanged, next state DONE.
REQ-029 Increment and not-taken branch: prog_ctr<=prog_ctr+1 modulo 2^D (all-ones wraps to 0).
REQ-030 Taken rel_branch: prog_ctr<=prog_ctr+sign-extended offset modulo 2^D.
REQ-031 abs_jump: prog_ctr<=lut_target.
REQ-032 call: push prog_ctr+1 (mod 2^D), prog_ctr<=lut_target; if stack already holds SD entries, push discarded, stack_err<=1, jump still taken.
REQ-033 ret: prog_ctr<=popped entry (LIFO); if stack empty, stack_err<=1 and prog_ctr<=prog_ctr+1.
REQ-034 stack_err SHALL remain 1 until reset or the next accepted start.
REQ-035 DONE SHALL last exactly one cycle then go to IDLE; prog_ctr holds the halt address through DONE and IDLE.
REQ-036 Return stack SHALL be internal, SD entries of D bits, with occupancy count 0..SD.

Reset
REQ-037 reset_n=0 SHALL immediately (asynchronously) force state IDLE, prog_ctr=0, busy=0, done=0, stack empty, stack_err=0, including mid-RUN or mid-DONE.
REQ-038 After reset_n deasserts, the block SHALL remain IDLE until start=1 is sampled.

Verification
REQ-039 Bench LUT index 1->17; start=1, prog_sel=1 -> next cycle prog_ctr=17, busy=1; three idle cycles -> prog_ctr=20.
REQ-040 prog_ctr=20, rel_branch=1, taken=1, offset=0xFB -> prog_ctr=15; taken=0 -> prog_ctr=21.
REQ-041 prog_ctr=30, call=1, jump_idx=3 (LUT 3->54) -> prog_ctr=54; ret=1 -> prog_ctr=31; ret=1 with stack empty -> prog_ctr=32, stack_err=1.
REQ-042 SD+1 nested calls -> fifth call jumps, stack_err=1; four rets return the four pushed addresses in reverse order.
REQ-043 halt=1 and call=1 together at prog_ctr=40 -> halt wins: done=1 one cycle, busy=0, prog_ctr=40, then IDLE; stall=1 with halt=1 -> no change.
REQ-044 prog_ctr=0xFFF increment -> 0x000; reset_n pulsed low mid-RUN -> prog_ctr=0, busy=0 without a clock edge.
